// File: rtl/nco_iq_synth.sv
// Purpose : octant-folded quarter-wave LUT that turns NCO octant codes into signed I/Q samples.
// Latency : 2 cycles from input handshake to out_valid (1 sample/cycle sustained).
// Backpres: out_valid && !out_ready freezes both stages; in_ready = !out_valid || out_ready.
//
// Ports:
//   clk, reset              - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       - octant-code beat handshake (addr, re_sig, im_sig, sel)
//   addr[WA-1:0]            - folded LUT address (odd octants already mirrored upstream)
//   re_sig / im_sig         - negate I / negate Q
//   sel                     - swap cos/sin table roles
//   out_valid/out_ready     - sample handshake; out_i/out_q signed DW-bit samples
//   sample_cnt[15:0]        - accepted-sample counter
//
// Build option: define NCO_IQ_SAMPLE_CNT_EN to enable the sample counter; otherwise
// sample_cnt is tied to zero and no counter logic is built.
module nco_iq_synth #(
  parameter int WA = 4,
  parameter int DW = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WA-1:0]        addr,
  input  logic                 re_sig,
  input  logic                 im_sig,
  input  logic                 sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_i,
  output logic signed [DW-1:0] out_q,
  output logic [15:0]          sample_cnt
);

  localparam int N   = 1 << WA;
  localparam int AMP = (1 << (DW - 1)) - 1;

  // Table entry k sits at the centre of its slot: angle = pi/4 * (k + 0.5) / N.
  // The angle never exceeds pi/4, so a short Taylor series is far more accurate
  // than the 1-LSB rounding applied afterwards.
  function automatic logic signed [DW-1:0] rom_val(input int k, input bit want_sin);
    real x;
    real term;
    real acc;
    int  v;
    x = 3.14159265358979323846 * (real'(k) + 0.5) / (4.0 * real'(N));
    if (want_sin) begin
      term = x;
      acc  = x;
      for (int n = 1; n < 10; n++) begin
        term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
        acc  = acc + term;
      end
    end else begin
      term = 1.0;
      acc  = 1.0;
      for (int n = 1; n < 10; n++) begin
        term = -term * x * x / (real'(2 * n - 1) * real'(2 * n));
        acc  = acc + term;
      end
    end
    v = $rtoi(real'(AMP) * acc + 0.5);
    return v[DW-1:0];
  endfunction

  logic signed [DW-1:0] cos_rom [N];
  logic signed [DW-1:0] sin_rom [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam logic signed [DW-1:0] COS_K = rom_val(g, 1'b0);
    localparam logic signed [DW-1:0] SIN_K = rom_val(g, 1'b1);
    assign cos_rom[g] = COS_K;
    assign sin_rom[g] = SIN_K;
  end

  // Stage 1: table lookup and control bits
  logic                 s1_vld_q, s1_vld_d;
  logic signed [DW-1:0] s1_cos_q, s1_cos_d;
  logic signed [DW-1:0] s1_sin_q, s1_sin_d;
  logic                 s1_re_q,  s1_re_d;
  logic                 s1_im_q,  s1_im_d;
  logic                 s1_sel_q, s1_sel_d;

  // Stage 2: mapped output sample
  logic                 out_vld_q, out_vld_d;
  logic signed [DW-1:0] out_i_q,   out_i_d;
  logic signed [DW-1:0] out_q_q,   out_q_d;

  logic                 adv;
  logic signed [DW-1:0] pre_i;
  logic signed [DW-1:0] pre_q;

  // Whole pipe moves together: it advances whenever the output slot is empty
  // or being drained, so a full pipe holds exactly two samples.
  assign adv      = !out_vld_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_cos_d  = s1_cos_q;
    s1_sin_d  = s1_sin_q;
    s1_re_d   = s1_re_q;
    s1_im_d   = s1_im_q;
    s1_sel_d  = s1_sel_q;
    out_vld_d = out_vld_q;
    out_i_d   = out_i_q;
    out_q_d   = out_q_q;

    pre_i = s1_sel_q ? s1_sin_q : s1_cos_q;
    pre_q = s1_sel_q ? s1_cos_q : s1_sin_q;

    if (adv) begin
      s1_vld_d = in_valid;
      // Data registers only load on real beats; bubbles carry only a cleared valid.
      if (in_valid) begin
        s1_cos_d = cos_rom[addr];
        s1_sin_d = sin_rom[addr];
        s1_re_d  = re_sig;
        s1_im_d  = im_sig;
        s1_sel_d = sel;
      end
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        // |pre| <= AMP, so the DW-bit negation cannot overflow.
        out_i_d = s1_re_q ? -pre_i : pre_i;
        out_q_d = s1_im_q ? -pre_q : pre_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld_q  <= 1'b0;
      s1_cos_q  <= '0;
      s1_sin_q  <= '0;
      s1_re_q   <= 1'b0;
      s1_im_q   <= 1'b0;
      s1_sel_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_i_q   <= '0;
      out_q_q   <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_cos_q  <= s1_cos_d;
      s1_sin_q  <= s1_sin_d;
      s1_re_q   <= s1_re_d;
      s1_im_q   <= s1_im_d;
      s1_sel_q  <= s1_sel_d;
      out_vld_q <= out_vld_d;
      out_i_q   <= out_i_d;
      out_q_q   <= out_q_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;

`ifdef NCO_IQ_SAMPLE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts output handshakes; natural 16-bit wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (out_vld_q && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample_cnt = cnt_q;
`else
  assign sample_cnt = 16'd0;
`endif

endmodule

// File: doc/nco_iq_synth.md
NCO_IQ_SYNTH -- requirements
Module: nco_iq_synth

Interface
REQ-001 Parameter WA, default 4: LUT address width, giving 2^WA entries per octant.
REQ-002 Parameter DW, default 12: signed I/Q sample width; amplitude A = 2^(DW-1)-1.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  octant-code beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 addr  input  WA  octant-folded LUT address, already mirrored by the NCO for odd octants.
REQ-008 re_sig  input  1  negate I when 1.
REQ-009 im_sig  input  1  negate Q when 1.
REQ-010 sel  input  1  swap cos/sin table roles when 1.
REQ-011 out_valid  output  1  I/Q sample present.
REQ-012 out_ready  input  1  downstream accepts sample.
REQ-013 out_i  output  DW  signed in-phase sample.
REQ-014 out_q  output  DW  signed quadrature sample.
REQ-015 sample_cnt  output  16  count of accepted output samples (see Configuration).

Function
REQ-016 Internal ROMs: COS[k]=round(A*cos(pi/4*(k+0.5)/2^WA)) and SIN[k]=round(A*sin(pi/4*(k+0.5)/2^WA)), for k=0..2^WA-1; contents fixed at elaboration.
REQ-017 Input handshake: a beat is accepted when in_valid && in_ready; output handshake: a sample transfers when out_valid && out_ready.
REQ-018 Two-stage pipeline. S1 registers COS[addr], SIN[addr], re_sig, im_sig, sel and a valid bit. S2 registers the final I/Q and out_valid.
REQ-019 Pipeline advance condition: adv = !out_valid || out_ready. in_ready = adv. When adv=0, both stages hold their contents unchanged.
REQ-020 S2 output mapping: pre_i = sel ? SIN : COS; pre_q = sel ? COS : SIN; out_i = re_sig ? -pre_i : pre_i; out_q = im_sig ? -pre_q : pre_q.
REQ-021 Negation is two's complement at DW bits. Magnitudes never exceed A, so no saturation logic exists and -A is the most negative output.
REQ-022 Latency: a beat accepted in cycle n appears with out_valid=1 in cycle n+2 when out_ready stays 1. Throughput is 1 sample/cycle.
REQ-023 Bubble handling: S1 valid=0 propagates to S2 as out_valid=0 when adv=1. Bubbles never produce a spurious sample.
REQ-024 When adv=1, the block accepts a new input and transfers an output in the same cycle; no beat is lost or duplicated.
REQ-025 Sample ordering is strictly preserved: FIFO, depth 2.
REQ-026 out_i and out_q are stable while out_valid=1 and out_ready=0.

Reset
REQ-027 reset low asynchronously clears S1 valid, out_valid, out_i, out_q and sample_cnt to 0.
REQ-028 in_ready=1 during reset and after reset deassertion. Beats in flight at reset assertion are discarded.
REQ-029 The first accepted beat after reset release follows REQ-022 latency exactly.

Configuration
REQ-030 Macro NCO_IQ_SAMPLE_CNT_EN defined: sample_cnt increments by 1 on each output handshake and wraps 16'hFFFF->0.
REQ-031 Macro NCO_IQ_SAMPLE_CNT_EN undefined: sample_cnt is tied to 0, no counter logic exists, and all other behaviour is identical.

Verification (WA=4, DW=12, A=2047)
REQ-032 Octant 0 beat addr=0, re/im/sel=0, out_ready=1 -> cycle n+2: out_i=2046, out_q=50, out_valid=1.
REQ-033 Beat addr=0, sel=1, re_sig=1, im_sig=0 (octant 2) -> out_i=-50, out_q=2046.
REQ-034 Full 8-octant sweep driven from a 7-bit phase counter with all 128 codes -> all |I|,|Q| <= 2047, I^2+Q^2 within 1% of 2047^2, and quadrant signs correct.
REQ-035 Stream 10 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while stalled, outputs held, all 10 samples delivered in order with none lost or duplicated.
REQ-036 Assert reset with 2 beats in flight -> out_valid=0 immediately; after release, next beat emerges at n+2 and sample_cnt restarts from 0 (macro on) or stays 0 (macro off).
